// File: rtl/dircc_pkg.sv
// dircc_pkg: definitions shared by the DIRCC router and its link FIFOs.
//   DIRCC_DATA_WIDTH  - Avalon-ST beat data width used across the node.
//   DIRCC_EMPTY_WIDTH - width of the empty-symbol count on eop beats.
//   dircc_beat_t      - one stored beat {sop, eop, empty, data}.
package dircc_pkg;

  localparam int DIRCC_DATA_WIDTH  = 32;
  localparam int DIRCC_EMPTY_WIDTH = 2;

  typedef struct packed {
    logic                         sop;
    logic                         eop;
    logic [DIRCC_EMPTY_WIDTH-1:0] empty;
    logic [DIRCC_DATA_WIDTH-1:0]  data;
  } dircc_beat_t;

endpackage

// File: rtl/dircc_link_fifo_if.sv
// dircc_link_fifo_if: one Avalon-ST packet link.
//   data/empty/startofpacket/endofpacket/valid travel source -> sink,
//   ready travels sink -> source.
//   master: the beat source; slave: the beat sink.
interface dircc_link_fifo_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
);

  logic [DATA_WIDTH-1:0]  data;
  logic                   valid;
  logic                   ready;
  logic                   startofpacket;
  logic                   endofpacket;
  logic [EMPTY_WIDTH-1:0] empty;

  modport master (
    output data, valid, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket, empty,
    output ready
  );

endinterface

// File: rtl/dircc_fifo_mem.sv
// dircc_fifo_mem: beat storage for the link FIFO.
//   clk   - write clock
//   we    - write enable; wdata is stored at waddr on the rising edge
//   raddr - read address; rdata follows it combinationally
// The array is deliberately not reset: occupancy is tracked by the
// owner, so stale entries are never presented as valid.
module dircc_fifo_mem #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/dircc_link_fifo.sv
// dircc_link_fifo: store-and-forward packet FIFO in front of one router
// input port. A packet is offered downstream only once its eop beat is
// stored; a packet that fills the whole buffer without an eop switches
// the FIFO to cut-through until that packet's eop leaves.
//   clk_clk, reset_reset_n - clock, asynchronous active-low reset
//   input_port  (slave)    - Avalon-ST sink from the link / local core
//   output_port (master)   - Avalon-ST source to the router
//   fill_level             - beats stored
//   pkt_count              - complete packets stored
//   framing_error          - sticky sop/eop protocol violation flag
module dircc_link_fifo
  import dircc_pkg::*;
#(
  parameter  int DATA_WIDTH  = DIRCC_DATA_WIDTH,
  parameter  int EMPTY_WIDTH = DIRCC_EMPTY_WIDTH,
  parameter  int DEPTH       = 16,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  dircc_link_fifo_if.slave  input_port,
  dircc_link_fifo_if.master output_port,
  output logic [CNT_W-1:0]  fill_level,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              framing_error
);

  // Stored word layout: {sop, eop, empty, data}.
  localparam int WORD_W = DATA_WIDTH + EMPTY_WIDTH + 2;
  localparam int SOP_B  = WORD_W - 1;
  localparam int EOP_B  = WORD_W - 2;

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  fill_r;
  logic [CNT_W-1:0]  pkt_r;
  logic [CNT_W-1:0]  fill_next_s;
  logic [CNT_W-1:0]  pkt_next_s;
  logic              ready_r;
  logic              cut_r;
  logic              in_pkt_r;
  logic              ferr_r;
  logic              push_s;
  logic              pop_s;
  logic              push_eop_s;
  logic              pop_eop_s;
  logic              valid_s;
  logic [WORD_W-1:0] wdata_s;
  logic [WORD_W-1:0] rdata_s;

  assign wdata_s = {input_port.startofpacket, input_port.endofpacket,
                    input_port.empty, input_port.data};

  dircc_fifo_mem #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk_clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  assign push_s     = input_port.valid & ready_r;
  assign pop_s      = valid_s & output_port.ready;
  assign push_eop_s = push_s & input_port.endofpacket;
  assign pop_eop_s  = pop_s & rdata_s[EOP_B];

  // Offer the head only when a whole packet is stored, or when a packet
  // too long for the buffer has forced cut-through.
  assign valid_s = (fill_r != {CNT_W{1'b0}}) &
                   ((pkt_r != {CNT_W{1'b0}}) | cut_r);

  // Occupancy next-state; a push and a pop in the same cycle cancel.
  always_comb begin
    fill_next_s = fill_r;
    pkt_next_s  = pkt_r;
    if (push_s && !pop_s) begin
      fill_next_s = fill_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      fill_next_s = fill_r - CNT_W'(1);
    end else begin
      fill_next_s = fill_r;
    end
    if (push_eop_s && !pop_eop_s) begin
      pkt_next_s = pkt_r + CNT_W'(1);
    end else if (pop_eop_s && !push_eop_s) begin
      pkt_next_s = pkt_r - CNT_W'(1);
    end else begin
      pkt_next_s = pkt_r;
    end
  end

  // Pointers, counters, ready register, cut-through and framing state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      fill_r   <= {CNT_W{1'b0}};
      pkt_r    <= {CNT_W{1'b0}};
      ready_r  <= 1'b0;
      cut_r    <= 1'b0;
      in_pkt_r <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      fill_r  <= fill_next_s;
      pkt_r   <= pkt_next_s;
      // Looks at the post-update level so ready never waits on output_ready.
      ready_r <= (fill_next_s < CNT_W'(DEPTH));
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      // A full buffer with no complete packet can only drain by streaming.
      if (pop_eop_s) begin
        cut_r <= 1'b0;
      end else if ((fill_r == CNT_W'(DEPTH)) && (pkt_r == {CNT_W{1'b0}})) begin
        cut_r <= 1'b1;
      end
      // Bad beats are still stored; only the sticky flag records them.
      if (push_s) begin
        if (input_port.startofpacket == in_pkt_r) begin
          ferr_r <= 1'b1;
        end
        in_pkt_r <= ~input_port.endofpacket;
      end
    end
  end

  // Head fields are forced to zero whenever no beat is offered.
  always_comb begin
    if (valid_s) begin
      output_port.data          = rdata_s[DATA_WIDTH-1:0];
      output_port.empty         = rdata_s[DATA_WIDTH+EMPTY_WIDTH-1:DATA_WIDTH];
      output_port.startofpacket = rdata_s[SOP_B];
      output_port.endofpacket   = rdata_s[EOP_B];
    end else begin
      output_port.data          = {DATA_WIDTH{1'b0}};
      output_port.empty         = {EMPTY_WIDTH{1'b0}};
      output_port.startofpacket = 1'b0;
      output_port.endofpacket   = 1'b0;
    end
  end

  assign output_port.valid = valid_s;
  assign input_port.ready  = ready_r;
  assign fill_level        = fill_r;
  assign pkt_count         = pkt_r;
  assign framing_error     = ferr_r;

endmodule

// File: tb/tb_dircc_link_fifo.sv
// tb_dircc_link_fifo: directed and random stimulus for dircc_link_fifo,
// checked every cycle against a queue-based packet model.
module tb_dircc_link_fifo;
  import dircc_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] fill_level;
  logic [CNT_W-1:0] pkt_count;
  logic             framing_error;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: stored beats plus the few flags the rules need.
  dircc_beat_t q[$];
  bit exp_ready  = 1'b0;
  bit exp_cut    = 1'b0;
  bit exp_in_pkt = 1'b0;
  bit exp_ferr   = 1'b0;

  dircc_link_fifo_if #(.DATA_WIDTH(32), .EMPTY_WIDTH(2)) in_if ();
  dircc_link_fifo_if #(.DATA_WIDTH(32), .EMPTY_WIDTH(2)) out_if ();

  dircc_link_fifo #(.DEPTH(DEPTH)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .input_port    (in_if),
    .output_port   (out_if),
    .fill_level    (fill_level),
    .pkt_count     (pkt_count),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag, input bit done);
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("FAIL %s: observed not-done expected done", tag);
    end
  endtask

  function automatic int count_eop();
    int n = 0;
    foreach (q[i]) if (q[i].eop) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_ready  = 1'b0;
    exp_cut    = 1'b0;
    exp_in_pkt = 1'b0;
    exp_ferr   = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_input_ready"}, in_if.ready, 1'b0);
    check({tag, "_output_valid"}, out_if.valid, 1'b0);
    check({tag, "_output_data"}, out_if.data, 32'h0);
    check({tag, "_output_sop"}, out_if.startofpacket, 1'b0);
    check({tag, "_output_eop"}, out_if.endofpacket, 1'b0);
    check({tag, "_output_empty"}, out_if.empty, 2'h0);
    check({tag, "_fill_level"}, fill_level, 5'h0);
    check({tag, "_pkt_count"}, pkt_count, 5'h0);
    check({tag, "_framing_error"}, framing_error, 1'b0);
  endtask

  // One clock: drive inputs, check outputs at negedge, advance model at posedge.
  task automatic cycle(input bit v, input bit s, input bit e, input logic [1:0] emp,
                       input logic [31:0] d, input bit ordy, output bit pushed);
    dircc_beat_t b;
    bit pop;
    bit exp_valid;
    int n_eop;
    int n_fill;
    in_if.valid         = v;
    in_if.startofpacket = s;
    in_if.endofpacket   = e;
    in_if.empty         = emp;
    in_if.data          = d;
    out_if.ready        = ordy;
    @(negedge clk);
    n_eop     = count_eop();
    n_fill    = q.size();
    exp_valid = (n_fill > 0) && ((n_eop > 0) || exp_cut);
    check("input_ready", in_if.ready, exp_ready);
    check("output_valid", out_if.valid, exp_valid);
    check("fill_level", fill_level, n_fill);
    check("pkt_count", pkt_count, n_eop);
    check("framing_error", framing_error, exp_ferr);
    if (exp_valid) begin
      check("output_data", out_if.data, q[0].data);
      check("output_sop", out_if.startofpacket, q[0].sop);
      check("output_eop", out_if.endofpacket, q[0].eop);
      check("output_empty", out_if.empty, q[0].empty);
    end
    pushed = v && exp_ready;
    pop    = exp_valid && ordy;
    @(posedge clk);
    if (pop && q[0].eop) exp_cut = 1'b0;
    else if ((n_fill == DEPTH) && (n_eop == 0)) exp_cut = 1'b1;
    if (pop) void'(q.pop_front());
    if (pushed) begin
      if (s == exp_in_pkt) exp_ferr = 1'b1;
      exp_in_pkt = !e;
      b.sop = s; b.eop = e; b.empty = emp; b.data = d;
      q.push_back(b);
    end
    exp_ready = (q.size() < DEPTH);
    #1;
  endtask

  // Offer one beat until accepted; rand_ordy randomizes output_ready meanwhile.
  task automatic send(input bit s, input bit e, input logic [1:0] emp,
                      input logic [31:0] d, input bit ordy, input bit rand_ordy);
    bit pushed = 1'b0;
    for (int k = 0; k < 200 && !pushed; k++)
      cycle(1'b1, s, e, emp, d, rand_ordy ? 1'($urandom_range(0, 1)) : ordy, pushed);
    timeout("send_timeout", pushed);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit p;
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 2'h0, 32'h0, ordy, p);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() > 0; k++) idle(1, 1'b1);
    timeout("drain_timeout", q.size() == 0);
    idle(1, 1'b1);
  endtask

  initial begin
    bit p;
    int len;
    in_if.valid = 1'b0; in_if.startofpacket = 1'b0; in_if.endofpacket = 1'b0;
    in_if.empty = 2'h0; in_if.data = 32'h0; out_if.ready = 1'b0;

    // Power-on reset, then ready rises on the first edge after release.
    #2;
    reset_checks("por");
    #15;
    rst_n = 1'b1;
    idle(2, 1'b0);

    // 3-beat packet held back until its eop is stored.
    send(1'b1, 1'b0, 2'h0, 32'hA0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 2'h0, 32'hA1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 2'h2, 32'hA2, 1'b0, 1'b0);
    idle(3, 1'b0);
    drain();

    // Back-to-back single-beat packets streaming through.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1, 2'h1, 32'hC0 + i, 1'b1, p);
    drain();

    // Fill to DEPTH, refused beat, one pop reopens ready.
    for (int i = 0; i < DEPTH; i++) send(1'b1, 1'b1, 2'h0, 32'hD0 + i, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 2'h0, 32'hEE, 1'b0, p);
    idle(1, 1'b1);
    idle(2, 1'b0);
    drain();

    // Packet longer than the buffer goes through in cut-through mode.
    for (int i = 0; i < 20; i++)
      send(i == 0, i == 19, (i == 19) ? 2'h3 : 2'h0, 32'h100 + i, 1'b1, 1'b0);
    drain();

    // Random well-formed packets with random gaps and backpressure.
    for (int pk = 0; pk < 40; pk++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom_range(0, 1)));
        send(b == 0, b == len - 1, (b == len - 1) ? 2'($urandom_range(0, 3)) : 2'h0,
             $urandom, 1'b0, 1'b1);
      end
    end
    drain();

    // Framing violations: sop inside a packet, then a non-sop beat while idle.
    send(1'b1, 1'b0, 2'h0, 32'hB0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 2'h1, 32'hB1, 1'b1, 1'b0);
    idle(1, 1'b1);
    send(1'b0, 1'b1, 2'h3, 32'hB2, 1'b1, 1'b0);
    drain();
    idle(2, 1'b1);

    // Reset mid-packet with 5 beats stored.
    for (int i = 0; i < 5; i++) send(i == 0, 1'b0, 2'h0, 32'hE0 + i, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dircc_link_fifo.md
# dircc_link_fifo

Store-and-forward packet FIFO placed directly upstream of each `dircc_routing` input port (north/south/east/west/poets). It buffers Avalon-ST packets arriving from a neighbouring node or the local POETS core and presents a packet to the router only once its last beat is stored, so the router never stalls mid-packet on a slow link. Packets longer than the buffer fall back to cut-through so they cannot deadlock.

## Interface

- `DATA_WIDTH`, 32: beat data width.
- `EMPTY_WIDTH`, 2: width of the `empty` symbol count.
- `DEPTH`, 16: buffer depth in beats; a power of two, ≥4.
- `clk_clk` in 1: single clock.
- `reset_reset_n` in 1: reset, asynchronous and active-low.
- `input_data` in DATA_WIDTH: sink beat data.
- `input_valid` in 1: sink valid.
- `input_ready` out 1: sink ready; registered.
- `input_startofpacket` in 1: first beat of a packet.
- `input_endofpacket` in 1: last beat of a packet.
- `input_empty` in EMPTY_WIDTH: empty symbols on the eop beat.
- `output_data` out DATA_WIDTH: source beat data; feeds the router `input_<dir>_data`.
- `output_valid` out 1: source valid.
- `output_ready` in 1: source ready, driven from the router.
- `output_startofpacket`, `output_endofpacket` out 1: framing.
- `output_empty` out EMPTY_WIDTH: empty symbols.
- `fill_level` out clog2(DEPTH)+1: stored beat count.
- `pkt_count` out clog2(DEPTH)+1: complete packets stored.
- `framing_error` out 1: sticky protocol-error flag.

## Operation

- Storage: DEPTH entries of {sop, eop, empty, data}, held in a register array with wrapping read and write pointers of clog2(DEPTH) bits.
- Push when `input_valid & input_ready`. Pop when `output_valid & output_ready`.
- `fill_level`: increments on push only, decrements on pop only, and is unchanged when both occur in the same cycle.
- `pkt_count`: increments on a push with eop, decrements on a pop with eop, and is unchanged when both occur.
- `cut_through` flag:
  - Set when `fill_level==DEPTH` and `pkt_count==0`.
  - Cleared on a pop with eop.
- `output_valid = (fill_level>0) & (pkt_count>0 | cut_through)`.
- Output fields are read combinationally from `mem[rd_ptr]`.
- Framing tracker (`in_pkt` bit). `framing_error` is set sticky, and cleared only by reset, when either occurs:
  - A push with sop while `in_pkt`.
  - A push without sop while `!in_pkt`.
- Erroneous beats are stored unchanged. A single beat with both sop and eop is legal.

## Timing

- Reset (asynchronous assert) forces:
  - pointers, `fill_level`, `pkt_count`, `cut_through`, `in_pkt` and `framing_error` to 0;
  - `input_ready` to 0 and `output_valid` to 0.
- `input_ready` rises on the first clock edge after `reset_reset_n` deasserts.
- `input_ready` is registered: it equals `next_fill_level < DEPTH`. It never depends combinationally on `output_ready`.
- When the buffer is full, a same-cycle pop reopens `input_ready` on the next cycle; the full cycle itself accepts nothing.
- Latency: the eop beat pushed at edge N makes `output_valid` high in the cycle after edge N, with the packet head on the output. Minimum packet latency is 1 cycle.
- Throughput: 1 beat/cycle on each side simultaneously.
- Output fields stay stable while `output_valid & !output_ready`.
- `output_valid` may drop between packets. Mid-packet it drops only in cut-through mode, when the buffer runs empty.
- Reset mid-packet discards all contents. The partial packet is lost; upstream re-sync is the sender's responsibility.

## Structure

- Shared package `dircc_pkg`:
  - the beat struct {sop, eop, empty, data};
  - `DIRCC_DATA_WIDTH=32` and `DIRCC_EMPTY_WIDTH=2`, shared with `dircc_routing`.
- One sub-module is natural: `dircc_fifo_mem`, a register array with a synchronous write port and an asynchronous read port.
- Counters, the ready register and the framing logic stay in the top module.
- Five instances are used per node, one per router input.

## Test plan

- Reset release; push a 3-beat packet (0xA0..0xA2, empty=2 on eop) with `output_ready=0`. Required: `output_valid` stays 0 until the cycle after beat 3, then rises; `pkt_count=1`, `fill_level=3`.
- Back-to-back 1-beat packets with `output_ready=1` held. Required: one beat out per cycle and `fill_level` constant at 1.
- Fill to 16 with `output_ready=0`. Required: `input_ready` drops the cycle after the 16th push. Pop one beat: `input_ready` returns the next cycle.
- Push a 20-beat packet with DEPTH=16. Required: cut-through engages at `fill_level=16` with `pkt_count=0`; all 20 beats emerge in order; the flag clears after the eop pop.
- Send a sop beat while in a packet, and separately a non-sop beat while idle. Required: `framing_error=1` persists, and the data still passes through unaltered.
- Assert `reset_reset_n` low mid-packet with 5 beats stored. Required: all outputs are 0 immediately; after release `fill_level=0` and `input_ready=1` one edge later.
